// File: rtl/parking_display_defs.sv
// Shared constants for the parking-lot display path: blank nibble, scheduler states, source indices.
package parking_display_defs;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } disp_state_t;

  localparam int SRC_ALARM = 0;
  localparam int SRC_ENTRY = 1;
  localparam int SRC_EXIT  = 2;
  localparam int SRC_FEE   = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_message_scheduler_if.sv
// Message sources on one side, the seven-segment driver on the other; the scheduler is the slave.
interface display_message_scheduler_if #(parameter int NUM_REQ = 4);

  logic [NUM_REQ-1:0]         req;
  logic [16*NUM_REQ-1:0]      req_digits;
  logic [15:0]                default_digits;
  logic [NUM_REQ-1:0]         grant;
  logic [3:0]                 digit_0;
  logic [3:0]                 digit_1;
  logic [3:0]                 digit_2;
  logic [3:0]                 digit_3;
  logic [$clog2(NUM_REQ)-1:0] active_src;
  logic                       busy;

  modport master (
    output req, req_digits, default_digits,
    input  grant, digit_0, digit_1, digit_2, digit_3, active_src, busy
  );

  modport slave (
    input  req, req_digits, default_digits,
    output grant, digit_0, digit_1, digit_2, digit_3, active_src, busy
  );

endinterface

// File: rtl/display_message_scheduler_rr_arbiter.sv
// Combinational round-robin pick over req[NUM_REQ-1:1], searching upward from rr_ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int W  = $clog2(NUM_REQ);
  localparam int IW = W + 1;
  localparam logic [W:0] LAST = IW'(NUM_REQ - 1);

  logic [W:0] idx;

  // Walk offsets from farthest to nearest so the closest requester to rr_ptr is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQ - 2; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + IW'(i);
      if (idx > LAST) idx = idx - LAST;
      if (req[idx[W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/display_message_scheduler.sv
// Time-shares the 4-digit display: show a granted message, blank for a gap, else show default digits.
module display_message_scheduler
  import parking_display_defs::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input logic                          clk,
  input logic                          reset,
  display_message_scheduler_if.slave   bus
);

  localparam int W  = $clog2(NUM_REQ);
  localparam int TW = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0] HOLD_T     = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] GAP_T      = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [W-1:0]  ALARM      = W'(SRC_ALARM);
  localparam logic [W-1:0]  FIRST_RR   = W'(1);
  localparam logic [W-1:0]  LAST_SRC   = W'(NUM_REQ - 1);
  localparam logic [15:0]   BLANK_WORD = {4{BLANK_DIGIT}};

  disp_state_t        state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [15:0]        digits_q, digits_d;
  logic [W-1:0]       src_q, src_d;
  logic               busy_q, busy_d;

  logic               arb_valid;
  logic [W-1:0]       arb_winner;
  logic               pick_valid;
  logic [W-1:0]       pick;
  logic               load;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // The alarm source always beats the round-robin candidate.
  always_comb begin
    pick_valid = bus.req[SRC_ALARM] | arb_valid;
    pick       = bus.req[SRC_ALARM] ? ALARM : arb_winner;
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = '0;
    digits_d = digits_q;
    src_d    = src_q;
    busy_d   = busy_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        digits_d = bus.default_digits;
        src_d    = '0;
        busy_d   = 1'b0;
        timer_d  = '0;
        load     = pick_valid;
      end
      SHOW: begin
        // An alarm cuts straight into another source's message; expiry loses to it.
        if (bus.req[SRC_ALARM] && (src_q != ALARM)) begin
          load = 1'b1;
        end else if (timer_q == HOLD_T) begin
          state_d  = GAP;
          timer_d  = T_ONE;
          digits_d = BLANK_WORD;
          src_d    = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      GAP: begin
        if (timer_q != GAP_T) begin
          timer_d = timer_q + T_ONE;
        end else if (pick_valid) begin
          load = 1'b1;
        end else begin
          state_d  = IDLE;
          timer_d  = '0;
          digits_d = bus.default_digits;
          busy_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Alarm grants leave the round-robin pointer where it was.
    if (load) begin
      state_d       = SHOW;
      timer_d       = T_ONE;
      grant_d[pick] = 1'b1;
      digits_d      = bus.req_digits[16*pick +: 16];
      src_d         = pick;
      busy_d        = 1'b1;
      if (pick != ALARM) rr_ptr_d = (pick == LAST_SRC) ? FIRST_RR : pick + FIRST_RR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      rr_ptr_q <= FIRST_RR;
      grant_q  <= '0;
      digits_q <= BLANK_WORD;
      src_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      digits_q <= digits_d;
      src_q    <= src_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.digit_0    = digits_q[15:12];
  assign bus.digit_1    = digits_q[11:8];
  assign bus.digit_2    = digits_q[7:4];
  assign bus.digit_3    = digits_q[3:0];
  assign bus.active_src = src_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_display_message_scheduler.sv
// Directed bench: expected grants go into a scoreboard queue, a negedge monitor pops and compares them.
module tb_display_message_scheduler;

  localparam logic [15:0] P0  = 16'hEEEE;
  localparam logic [15:0] P1  = 16'h5678;
  localparam logic [15:0] P2  = 16'h1234;
  localparam logic [15:0] P3  = 16'h9ABC;
  localparam logic [15:0] DEF = 16'h0125;

  typedef struct {
    int          at;
    logic [3:0]  grant;
    logic [15:0] digits;
    int          src;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] hold_mask;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];

  display_message_scheduler_if #(.NUM_REQ(4)) bus ();

  display_message_scheduler #(
    .NUM_REQ     (4),
    .HOLD_CYCLES (8),
    .GAP_CYCLES  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] shown();
    return {bus.digit_0, bus.digit_1, bus.digit_2, bus.digit_3};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] set_mask);
    bus.req = bus.req | set_mask;
  endtask

  task automatic expectGrant(input int at, input int src, input logic [15:0] digits);
    exp_t e;
    e.at     = at;
    e.grant  = 4'b0001 << src;
    e.digits = digits;
    e.src    = src;
    exp_q.push_back(e);
  endtask

  // Requesters drop req on seeing their grant, unless asked to hold it one more request.
  task automatic stepCycle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (bus.grant[i] === 1'b1) begin
        if (hold_mask[i]) hold_mask[i] = 1'b0;
        else bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (bus.busy !== 1'b0 && n < 60);
    checkOutput({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({name, "_digits"}, {16'd0, shown()}, {16'd0, DEF});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.grant !== 4'b0000 && reset === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_grant at cycle %0d: got %b expected none", cyc, bus.grant);
      end else begin
        e = exp_q.pop_front();
        checkOutput("grant_vector", {28'd0, bus.grant}, {28'd0, e.grant});
        checkOutput("grant_cycle", cyc, e.at);
        checkOutput("grant_digits", {16'd0, shown()}, {16'd0, e.digits});
        checkOutput("grant_src", {30'd0, bus.active_src}, e.src);
        checkOutput("grant_busy", {31'd0, bus.busy}, 32'd1);
      end
    end
  end

  initial begin
    int c;
    reset              = 1'b1;
    hold_mask          = 4'b0000;
    bus.req            = 4'b0000;
    bus.req_digits     = {P3, P2, P1, P0};
    bus.default_digits = DEF;
    stepCycle();
    stepCycle();

    // Reset values, then default digits one cycle after release.
    checkOutput("rst_digits", {16'd0, shown()}, 32'h0000FFFF);
    checkOutput("rst_grant", {28'd0, bus.grant}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_src", {30'd0, bus.active_src}, 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("idle_digits", {16'd0, shown()}, {16'd0, DEF});
    checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Three requesters from reset: rr_ptr=1 gives order 1,2,3.
    c = cyc;
    applyStimulus(4'b1110);
    expectGrant(c + 1, 1, P1);
    expectGrant(c + 11, 2, P2);
    expectGrant(c + 21, 3, P3);
    repeat (9) stepCycle();
    checkOutput("rr_a_gap_digits", {16'd0, shown()}, 32'h0000FFFF);
    checkOutput("rr_a_gap_busy", {31'd0, bus.busy}, 32'd1);
    waitIdle("rr_a_idle");

    // Single source 2: 8 cycles shown, 2 blank, then default.
    c = cyc;
    applyStimulus(4'b0100);
    expectGrant(c + 1, 2, P2);
    for (int j = 0; j <= 10; j++) begin
      stepCycle();
      if (j < 8) begin
        checkOutput("single_show", {16'd0, shown()}, {16'd0, P2});
        checkOutput("single_src", {30'd0, bus.active_src}, 32'd2);
      end else if (j < 10) begin
        checkOutput("single_gap", {16'd0, shown()}, 32'h0000FFFF);
        checkOutput("single_gap_src", {30'd0, bus.active_src}, 32'd0);
      end else begin
        checkOutput("single_back", {16'd0, shown()}, {16'd0, DEF});
      end
      checkOutput("single_busy", {31'd0, bus.busy}, (j < 10) ? 32'd1 : 32'd0);
      if (j == 1) checkOutput("single_grant_pulse", {28'd0, bus.grant}, 32'd0);
    end

    // rr_ptr now 3: order 3,1,2.
    c = cyc;
    applyStimulus(4'b1110);
    expectGrant(c + 1, 3, P3);
    expectGrant(c + 11, 1, P1);
    expectGrant(c + 21, 2, P2);
    waitIdle("rr_b_idle");

    // Alarm raised in cycle 4 of source-3 SHOW preempts without a gap.
    c = cyc;
    applyStimulus(4'b1000);
    expectGrant(c + 1, 3, P3);
    repeat (4) stepCycle();
    applyStimulus(4'b0001);
    expectGrant(c + 5, 0, P0);
    for (int j = 0; j <= 10; j++) begin
      stepCycle();
      if (j < 8) checkOutput("preempt_show", {16'd0, shown()}, {16'd0, P0});
      else if (j < 10) checkOutput("preempt_gap", {16'd0, shown()}, 32'h0000FFFF);
      else checkOutput("preempt_back", {16'd0, shown()}, {16'd0, DEF});
    end

    // req[1] rising on the expiry edge still waits out the gap; holding it past grant re-requests.
    c = cyc;
    applyStimulus(4'b1000);
    expectGrant(c + 1, 3, P3);
    repeat (8) stepCycle();
    hold_mask = 4'b0010;
    applyStimulus(4'b0010);
    expectGrant(c + 11, 1, P1);
    expectGrant(c + 21, 1, P1);
    for (int j = 0; j < 2; j++) begin
      stepCycle();
      checkOutput("expiry_gap", {16'd0, shown()}, 32'h0000FFFF);
    end
    waitIdle("expiry_idle");

    // Reset in cycle 5 of SHOW drops the message; pending source 3 waits for release.
    c = cyc;
    applyStimulus(4'b1100);
    expectGrant(c + 1, 2, P2);
    repeat (5) stepCycle();
    reset = 1'b1;
    stepCycle();
    checkOutput("midrst_digits", {16'd0, shown()}, 32'h0000FFFF);
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_src", {30'd0, bus.active_src}, 32'd0);
    checkOutput("midrst_grant", {28'd0, bus.grant}, 32'd0);
    stepCycle();
    checkOutput("midrst_hold_grant", {28'd0, bus.grant}, 32'd0);
    reset = 1'b0;
    expectGrant(c + 8, 3, P3);
    waitIdle("midrst_idle");

    repeat (3) stepCycle();
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
